// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, grant identity and
// the latency-counter sizing helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } arb_gnt_t;

    // Counter must hold LAT-1 and never shrink below one bit (LAT=1 case).
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one fixed-latency memory between the
// fetch (I) and memory-stage (D) ports, with per-stage stall outputs.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          stall_f,
    output logic          stall_m
);

    localparam int            CW       = cnt_width(LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    arb_state_t    state_q, state_d;
    arb_gnt_t      gnt_q, gnt_d;
    arb_gnt_t      last_q, last_d;
    arb_gnt_t      win;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_I;
            last_q    <= GNT_I;
            cnt_q     <= '0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        win       = GNT_I;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // On a tie the port that lost the previous decision wins.
                    if (i_req && d_req) begin
                        win = (last_q == GNT_I) ? GNT_D : GNT_I;
                    end else if (d_req) begin
                        win = GNT_D;
                    end else begin
                        win = GNT_I;
                    end
                    gnt_d   = win;
                    last_d  = win;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                    if (win == GNT_D) begin
                        m_addr_d  = d_addr;
                        m_we_d    = d_we;
                        m_wdata_d = d_wdata;
                    end else begin
                        m_addr_d  = i_addr;
                        m_we_d    = 1'b0;
                        m_wdata_d = '0;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (gnt_q == GNT_I) begin
                        i_rdata_d = m_rdata;
                    end else if (!m_we_q) begin
                        d_rdata_d = m_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_en    = (state_q == BUSY);
    assign m_we    = m_en & m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ready = (state_q == RESP) && (gnt_q == GNT_I);
    assign d_ready = (state_q == RESP) && (gnt_q == GNT_D);
    assign stall_f = i_req & ~i_ready;
    assign stall_m = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model predicts every access and a
// monitor checks the DUT bus, stalls and ready pulses against it.
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;

    typedef struct {
        int            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            grant;
    } acc_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] i_rdata, d_rdata, m_wdata, m_rdata;
    logic [AW-1:0] m_addr;
    logic          i_ready, d_ready, m_en, m_we, stall_f, stall_m;

    logic          i1_req = 1'b0;
    logic [AW-1:0] i1_addr = '0, m1_addr;
    logic [DW-1:0] i1_rdata, d1_rdata, m1_wdata, m1_rdata;
    logic          i1_ready, d1_ready, m1_en, m1_we, stall1_f, stall1_m;

    always #5 clk = ~clk;

    mem_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .stall_f(stall_f), .stall_m(stall_m)
    );

    mem_arbiter #(.LAT(1), .AW(AW), .DW(DW)) u_dut1 (
        .clk(clk), .reset(reset),
        .i_req(i1_req), .i_addr(i1_addr), .i_rdata(i1_rdata), .i_ready(i1_ready),
        .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
        .d_rdata(d1_rdata), .d_ready(d1_ready),
        .m_en(m1_en), .m_we(m1_we), .m_addr(m1_addr), .m_wdata(m1_wdata), .m_rdata(m1_rdata),
        .stall_f(stall1_f), .stall_m(stall1_m)
    );

    function automatic logic [DW-1:0] init_val(input logic [5:0] idx);
        if (idx == 6'd0) return 32'hE04F_000F;
        return 32'hA500_0000 + ({26'd0, idx} * 32'h0001_0101);
    endfunction

    // Memory for the LAT=2 instance: registered read, valid only on the last
    // m_en cycle; writes land on that same last cycle.
    logic [DW-1:0] mem [64];
    bit            mem_wr [64];
    int            en_cnt = 0;

    always @(posedge clk) begin
        if (m_en && en_cnt == LAT - 2)
            m_rdata <= mem_wr[m_addr[7:2]] ? mem[m_addr[7:2]] : init_val(m_addr[7:2]);
        else
            m_rdata <= 32'hDEAD_BEEF;
        if (m_en && m_we && en_cnt == LAT - 1) begin
            mem[m_addr[7:2]]    <= m_wdata;
            mem_wr[m_addr[7:2]] <= 1'b1;
        end
        en_cnt <= m_en ? en_cnt + 1 : 0;
    end

    // Memory for the LAT=1 instance: read-only, data valid during its single m_en cycle.
    assign m1_rdata = m1_en ? init_val(m1_addr[7:2]) : 32'hDEAD_BEEF;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rst_chk_cyc = -1;

    acc_t acc_q[$];
    acc_t acc1_q[$];

    // Reference model state.
    logic [DW-1:0] ref_mem [64];
    bit            ref_wr [64];
    bit            act [2];
    bit            granted [2];
    int            due [2];
    int            gap [2];
    logic [AW-1:0] t_addr [2];
    bit            t_we [2];
    logic [DW-1:0] t_wdata [2];
    int            free_at = 0;
    int            last_port = 0;
    logic [DW-1:0] d_exp_rd = '0;
    bit            auto_en = 0;
    int            gap_max = 0;
    bit            s1_en = 0;
    bit            act1 = 0, gnt1 = 0;
    int            due1 = 0, free1 = 0;
    logic [AW-1:0] addr1 = '0;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_wr[a[7:2]] ? ref_mem[a[7:2]] : init_val(a[7:2]);
    endfunction

    task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act_v, exp_v);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s cycle=%0d got=event expected=none", name, cyc);
    endtask

    task automatic issue(input int p, input logic [AW-1:0] a, input bit we, input logic [DW-1:0] wd);
        act[p]     = 1'b1;
        granted[p] = 1'b0;
        t_addr[p]  = a;
        t_we[p]    = we;
        t_wdata[p] = wd;
    endtask

    task automatic begin_cycle();
        bit prev;
        @(posedge clk);
        #1;
        cyc++;
        prev  = reset;
        reset = 1'b0;
        if (prev) begin
            acc_q.delete();
            acc1_q.delete();
            for (int p = 0; p < 2; p++) begin
                act[p]     = 1'b0;
                granted[p] = 1'b0;
            end
            act1        = 1'b0;
            gnt1        = 1'b0;
            free_at     = cyc;
            free1       = cyc;
            last_port   = 0;
            d_exp_rd    = '0;
            rst_chk_cyc = cyc;
        end
        for (int p = 0; p < 2; p++) begin
            if (act[p] && granted[p] && due[p] == cyc - 1) begin
                act[p]     = 1'b0;
                granted[p] = 1'b0;
            end
        end
        if (act1 && gnt1 && due1 == cyc - 1) begin
            act1 = 1'b0;
            gnt1 = 1'b0;
        end
    endtask

    task automatic end_cycle();
        int   win;
        acc_t e;
        for (int p = 0; p < 2; p++) begin
            if (auto_en && !act[p] && !reset) begin
                if (gap[p] == 0) begin
                    issue(p, {24'd0, 6'($urandom_range(0, 31)), 2'b00},
                          (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom);
                    gap[p] = $urandom_range(0, gap_max);
                end else begin
                    gap[p]--;
                end
            end
        end
        if (s1_en && !act1 && !reset) begin
            act1  = 1'b1;
            gnt1  = 1'b0;
            addr1 = addr1 + 32'd4;
        end
        if (reset) begin
            for (int p = 0; p < 2; p++) act[p] = 1'b0;
            act1 = 1'b0;
        end
        i_req   = act[0];
        i_addr  = t_addr[0];
        d_req   = act[1];
        d_we    = t_we[1];
        d_addr  = t_addr[1];
        d_wdata = t_wdata[1];
        i1_req  = act1;
        i1_addr = addr1;

        win = -1;
        if (!reset && cyc >= free_at) begin
            if (act[0] && !granted[0] && act[1] && !granted[1]) win = (last_port == 0) ? 1 : 0;
            else if (act[1] && !granted[1]) win = 1;
            else if (act[0] && !granted[0]) win = 0;
        end
        if (win >= 0) begin
            e.port  = win;
            e.we    = (win == 1) ? t_we[1] : 1'b0;
            e.addr  = t_addr[win];
            e.wdata = t_wdata[win];
            e.grant = cyc;
            if (win == 0) begin
                e.rdata = ref_read(e.addr);
            end else if (e.we) begin
                ref_mem[e.addr[7:2]] = e.wdata;
                ref_wr[e.addr[7:2]]  = 1'b1;
                e.rdata = d_exp_rd;
            end else begin
                d_exp_rd = ref_read(e.addr);
                e.rdata  = d_exp_rd;
            end
            granted[win] = 1'b1;
            due[win]     = cyc + LAT + 1;
            free_at      = cyc + LAT + 2;
            last_port    = win;
            acc_q.push_back(e);
        end
        if (!reset && act1 && !gnt1 && cyc >= free1) begin
            e.port  = 0;
            e.we    = 1'b0;
            e.addr  = addr1;
            e.wdata = '0;
            e.rdata = init_val(addr1[7:2]);
            e.grant = cyc;
            gnt1    = 1'b1;
            due1    = cyc + 2;
            free1   = cyc + 3;
            acc1_q.push_back(e);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n && (act[0] || act[1] || act1); k++) begin
            begin_cycle();
            end_cycle();
        end
        run(1);
    endtask

    // Monitor: compares DUT activity against the head of the expected queues.
    initial begin
        bit   exp_i, exp_d, exp_1;
        int   en_seen, en1_seen;
        acc_t h;
        en_seen  = 0;
        en1_seen = 0;
        forever begin
            @(negedge clk);
            if (cyc == rst_chk_cyc) begin
                check("rst_m_en", m_en, 0);
                check("rst_m_we", m_we, 0);
                check("rst_m_addr", m_addr, 0);
                check("rst_m_wdata", m_wdata, 0);
                check("rst_i_rdata", i_rdata, 0);
                check("rst_d_rdata", d_rdata, 0);
                check("rst_ready", {i_ready, d_ready}, 0);
                check("rst1_bus", {m1_en, m1_we, m1_wdata, i1_rdata}, 0);
                check("rst1_d_port", {d1_ready, stall1_m, d1_rdata}, 0);
                en_seen  = 0;
                en1_seen = 0;
            end

            if (m_en) begin
                if (acc_q.size() > 0 && cyc > acc_q[0].grant && cyc <= acc_q[0].grant + LAT) begin
                    h = acc_q[0];
                    check("m_addr", m_addr, h.addr);
                    check("m_we", m_we, h.we);
                    if (h.we) check("m_wdata", m_wdata, h.wdata);
                    en_seen++;
                end else begin
                    flag("m_en_unexpected");
                end
            end
            exp_i = acc_q.size() > 0 && acc_q[0].port == 0 && acc_q[0].grant + LAT + 1 == cyc;
            exp_d = acc_q.size() > 0 && acc_q[0].port == 1 && acc_q[0].grant + LAT + 1 == cyc;
            check("stall_f", stall_f, i_req && !exp_i);
            check("stall_m", stall_m, d_req && !exp_d);
            if (i_ready || d_ready || exp_i || exp_d) begin
                check("i_ready", i_ready, exp_i);
                check("d_ready", d_ready, exp_d);
                if (exp_i || exp_d) begin
                    h = acc_q.pop_front();
                    if (exp_i) check("i_rdata", i_rdata, h.rdata);
                    else       check("d_rdata", d_rdata, h.rdata);
                    check("m_en_cycles", en_seen, LAT);
                    en_seen = 0;
                end
            end

            if (m1_en) begin
                if (acc1_q.size() > 0 && cyc == acc1_q[0].grant + 1) begin
                    check("m1_addr", m1_addr, acc1_q[0].addr);
                    check("m1_we", m1_we, 0);
                    en1_seen++;
                end else begin
                    flag("m1_en_unexpected");
                end
            end
            exp_1 = acc1_q.size() > 0 && acc1_q[0].grant + 2 == cyc;
            check("stall1_f", stall1_f, i1_req && !exp_1);
            if (i1_ready || exp_1) begin
                check("i1_ready", i1_ready, exp_1);
                if (exp_1) begin
                    h = acc1_q.pop_front();
                    check("i1_rdata", i1_rdata, h.rdata);
                    check("m1_en_cycles", en1_seen, 1);
                    check("d1_idle", {d1_ready, d1_rdata}, 0);
                    en1_seen = 0;
                end
            end
        end
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            t_addr[p]  = '0;
            t_we[p]    = 1'b0;
            t_wdata[p] = '0;
            gap[p]     = 0;
            due[p]     = 0;
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            begin_cycle();
            reset = 1'b1;
            end_cycle();
        end

        begin_cycle(); issue(0, 32'h0, 1'b0, '0); end_cycle();
        drain(20);
        begin_cycle(); issue(1, 32'h64, 1'b1, 32'd7); end_cycle();
        drain(20);

        begin_cycle(); reset = 1'b1; end_cycle();
        begin_cycle(); issue(0, 32'h8, 1'b0, '0); issue(1, 32'h64, 1'b0, '0); end_cycle();
        drain(30);

        auto_en = 1'b1;
        gap_max = 0;
        run(40);
        auto_en = 1'b0;
        drain(30);

        begin_cycle(); issue(1, 32'h10, 1'b0, '0); end_cycle();
        run(1);
        begin_cycle(); reset = 1'b1; end_cycle();
        begin_cycle(); issue(0, 32'h4, 1'b0, '0); end_cycle();
        drain(20);

        s1_en   = 1'b1;
        auto_en = 1'b1;
        gap_max = 3;
        run(600);
        s1_en   = 1'b0;
        auto_en = 1'b0;
        drain(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
